// File: rtl/frb_excess_detect_pkg.sv
// Shared definitions for the FRB excess detector: averager-compatible sample
// format defaults, detector state encoding and the excess width rule.
package frb_excess_detect_pkg;

  localparam int DIN_WIDTH_DEF = 32;
  localparam int DIN_POINT_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // One guard bit makes din - avg exact for any pair of in-range samples.
  function automatic int excess_width(input int din_width);
    return din_width + 1;
  endfunction

endpackage

// File: rtl/frb_excess_detect_sample_align_fifo.sv
// Register-based synchronous FIFO that holds raw samples until the averager
// output for the same sample arrives.
module frb_excess_detect_sample_align_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             pop_ok,
  output logic             ovf_evt,
  output logic             udf_evt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sample_align_fifo: DEPTH must be a power of 2 and at least 2");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             empty_s;
  logic             full_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Access arbitration and next-state for pointers and storage
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop_ok_s  = pop && !empty_s;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    push_ok_s = push && (!full_s || pop_ok_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok  = pop_ok_s;
  assign ovf_evt = push && !push_ok_s;
  assign udf_evt = pop && empty_s;

endmodule

// File: rtl/frb_excess_detect.sv
// Aligns raw samples with their moving-average baseline, computes the excess
// and reports one event per above-threshold run, followed by a holdoff window.
module frb_excess_detect
  import frb_excess_detect_pkg::*;
#(
  parameter int DIN_WIDTH   = DIN_WIDTH_DEF,
  parameter int DIN_POINT   = DIN_POINT_DEF,
  parameter int FIFO_DEPTH  = 8,
  parameter int MIN_RUN     = 2,
  parameter int HOLDOFF_LEN = 16,
  parameter int LEN_WIDTH   = 8,
  parameter int TS_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic [DIN_WIDTH-1:0] avg,
  input  logic                 avg_valid,
  input  logic [DIN_WIDTH:0]   thresh,
  output logic                 detect,
  output logic [TS_WIDTH-1:0]  det_time,
  output logic [DIN_WIDTH:0]   det_peak,
  output logic [LEN_WIDTH-1:0] det_len,
  output logic                 busy,
  output logic                 fifo_ovf,
  output logic                 align_err
);

  localparam int EX_W   = excess_width(DIN_WIDTH);
  localparam int HCNT_W = (HOLDOFF_LEN < 2) ? 1 : $clog2(HOLDOFF_LEN + 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX    = {LEN_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0] MIN_RUN_L  = LEN_WIDTH'(MIN_RUN);
  localparam logic [HCNT_W-1:0]    HOLD_INIT  = HCNT_W'(HOLDOFF_LEN);

  if (DIN_POINT < 0 || DIN_POINT >= DIN_WIDTH || MIN_RUN < 1) begin : g_bad_params
    $error("frb_excess_detect: DIN_POINT must lie inside DIN_WIDTH and MIN_RUN must be >= 1");
  end

  logic [DIN_WIDTH-1:0] head_s;
  logic                 pop_ok_s;
  logic                 ovf_evt_s;
  logic                 udf_evt_s;

  frb_excess_detect_sample_align_fifo #(
    .WIDTH (DIN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_sample_align_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (din_valid),
    .wdata   (din),
    .pop     (avg_valid),
    .rdata   (head_s),
    .pop_ok  (pop_ok_s),
    .ovf_evt (ovf_evt_s),
    .udf_evt (udf_evt_s)
  );

  logic signed [EX_W-1:0] head_ext_s, avg_ext_s, diff_s;
  logic signed [EX_W-1:0] ex_q, ex_d;
  logic                   ex_valid_q, ex_valid_d;
  logic [TS_WIDTH-1:0]    ex_ts_q, ex_ts_d;
  logic [TS_WIDTH-1:0]    idx_q, idx_d;
  logic                   above_s;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   run_cnt_q, run_cnt_d;
  logic signed [EX_W-1:0] peak_q, peak_d;
  logic [TS_WIDTH-1:0]    start_ts_q, start_ts_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
  logic                   detect_q, detect_d;
  logic [TS_WIDTH-1:0]    det_time_q, det_time_d;
  logic [EX_W-1:0]        det_peak_q, det_peak_d;
  logic [LEN_WIDTH-1:0]   det_len_q, det_len_d;
  logic                   busy_q, busy_d;
  logic                   fifo_ovf_q, fifo_ovf_d;
  logic                   align_err_q, align_err_d;

  // Excess stage: subtract baseline from the aligned raw sample on each good pop
  always_comb begin
    head_ext_s = {head_s[DIN_WIDTH-1], head_s};
    avg_ext_s  = {avg[DIN_WIDTH-1], avg};
    diff_s     = head_ext_s - avg_ext_s;
    ex_valid_d = pop_ok_s;
    if (pop_ok_s) begin
      ex_d    = diff_s;
      ex_ts_d = idx_q;
      idx_d   = idx_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      ex_d    = ex_q;
      ex_ts_d = ex_ts_q;
      idx_d   = idx_q;
    end
    fifo_ovf_d  = fifo_ovf_q | ovf_evt_s;
    align_err_d = align_err_q | udf_evt_s;
  end

  assign above_s = ex_q > $signed(thresh);

  // Run detector next-state and event outputs; only evaluated samples advance it
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    peak_d     = peak_q;
    start_ts_d = start_ts_q;
    hcnt_d     = hcnt_q;
    detect_d   = 1'b0;
    det_time_d = det_time_q;
    det_peak_d = det_peak_q;
    det_len_d  = det_len_q;
    if (ex_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (above_s) begin
            state_d    = ST_RUN;
            run_cnt_d  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            peak_d     = ex_q;
            start_ts_d = ex_ts_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (above_s) begin
            if (run_cnt_q != LEN_MAX) begin
              run_cnt_d = run_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              run_cnt_d = run_cnt_q;
            end
            if (ex_q > peak_q) begin
              peak_d = ex_q;
            end else begin
              peak_d = peak_q;
            end
          end else if (run_cnt_q >= MIN_RUN_L) begin
            detect_d   = 1'b1;
            det_time_d = start_ts_q;
            det_peak_d = peak_q;
            det_len_d  = run_cnt_q;
            if (HOLDOFF_LEN == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLDOFF;
              hcnt_d  = HOLD_INIT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          hcnt_d = hcnt_q - {{(HCNT_W-1){1'b0}}, 1'b1};
          if (hcnt_q <= {{(HCNT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // All datapath, detector and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      ex_ts_q     <= '0;
      idx_q       <= '0;
      state_q     <= ST_IDLE;
      run_cnt_q   <= '0;
      peak_q      <= '0;
      start_ts_q  <= '0;
      hcnt_q      <= '0;
      detect_q    <= 1'b0;
      det_time_q  <= '0;
      det_peak_q  <= '0;
      det_len_q   <= '0;
      busy_q      <= 1'b0;
      fifo_ovf_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      ex_ts_q     <= ex_ts_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      peak_q      <= peak_d;
      start_ts_q  <= start_ts_d;
      hcnt_q      <= hcnt_d;
      detect_q    <= detect_d;
      det_time_q  <= det_time_d;
      det_peak_q  <= det_peak_d;
      det_len_q   <= det_len_d;
      busy_q      <= busy_d;
      fifo_ovf_q  <= fifo_ovf_d;
      align_err_q <= align_err_d;
    end
  end

  assign detect    = detect_q;
  assign det_time  = det_time_q;
  assign det_peak  = det_peak_q;
  assign det_len   = det_len_q;
  assign busy      = busy_q;
  assign fifo_ovf  = fifo_ovf_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_frb_excess_detect.sv
// Directed bench for frb_excess_detect with default parameters
// (MIN_RUN=2, HOLDOFF_LEN=16, FIFO_DEPTH=8, LEN_WIDTH=8).
module tb_frb_excess_detect;

  localparam int W  = 32;
  localparam int EW = 33;
  localparam logic [W-1:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din, avg;
  logic          din_valid, avg_valid;
  logic [EW-1:0] thresh;
  logic          detect;
  logic [31:0]   det_time;
  logic [EW-1:0] det_peak;
  logic [7:0]    det_len;
  logic          busy, fifo_ovf, align_err;

  int n_checks = 0;
  int n_fail   = 0;
  int det_cnt  = 0;
  int idx      = 0;

  frb_excess_detect dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .avg       (avg),
    .avg_valid (avg_valid),
    .thresh    (thresh),
    .detect    (detect),
    .det_time  (det_time),
    .det_peak  (det_peak),
    .det_len   (det_len),
    .busy      (busy),
    .fifo_ovf  (fifo_ovf),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  // Counts detect pulses using the value held during the cycle just ending
  always @(posedge clk) if (detect) det_cnt <= det_cnt + 1;

  // One aligned sample: push din, then pop with its baseline; returns at the
  // negedge of the cycle after the pop (ex_valid cycle).
  task automatic smp(input logic [W-1:0] d, input logic [W-1:0] a);
    din = d; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; avg = a; avg_valid = 1'b1;
    @(negedge clk);
    avg_valid = 1'b0;
    idx++;
  endtask

  task automatic xs(input int e);
    smp(BASE + 32'(e), BASE);
  endtask

  task automatic below(input int n);
    repeat (n) xs(0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; din = '0; avg = '0; din_valid = 1'b0; avg_valid = 1'b0; thresh = 33'h0_0000_0080;
    idle(2);
    n_checks++; if (detect !== 1'b0) begin n_fail++; $display("FAIL reset_detect: got %0b want 0", detect); end
    n_checks++; if (det_time !== 32'd0) begin n_fail++; $display("FAIL reset_det_time: got %0d want 0", det_time); end
    n_checks++; if (det_len !== 8'd0) begin n_fail++; $display("FAIL reset_det_len: got %0d want 0", det_len); end
    n_checks++; if (busy !== 1'b0 || fifo_ovf !== 1'b0 || align_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%0b ovf=%0b aerr=%0b want 000", busy, fifo_ovf, align_err); end
    rst = 1'b0; idx = 0;
    idle(1);
  endtask

  task automatic test_basic;
    int d0;
    d0 = det_cnt;
    below(10);
    repeat (3) xs(256);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_run: got %0b want 1", busy); end
    xs(0);
    n_checks++; if (detect !== 1'b0) begin n_fail++; $display("FAIL basic_early: detect at t+1 got %0b want 0", detect); end
    idle(1);
    n_checks++; if (detect !== 1'b1) begin n_fail++; $display("FAIL basic_latency: detect at t+2 got %0b want 1", detect); end
    n_checks++; if (det_time !== 32'd10) begin n_fail++; $display("FAIL basic_time: got %0d want 10", det_time); end
    n_checks++; if (det_len !== 8'd3) begin n_fail++; $display("FAIL basic_len: got %0d want 3", det_len); end
    n_checks++; if (det_peak !== 33'h0_0000_0100) begin n_fail++; $display("FAIL basic_peak: got %0h want 100", det_peak); end
    idle(1);
    n_checks++; if (detect !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_pulse: got detect=%0b busy=%0b want 0,1", detect, busy); end
    below(15);
    idle(1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_holdoff15: got busy=%0b want 1", busy); end
    below(1);
    idle(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_holdoff_end: got busy=%0b want 0", busy); end
    n_checks++; if (det_cnt !== d0 + 1) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", det_cnt - d0, 1); end
  endtask

  task automatic test_short_run;
    int d0;
    d0 = det_cnt;
    xs(256);
    idle(1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL short_busy: got %0b want 1", busy); end
    xs(0);
    idle(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL short_busy_drop: got %0b want 0", busy); end
    idle(2);
    n_checks++; if (det_cnt !== d0) begin n_fail++; $display("FAIL short_no_event: got %0d events want 0", det_cnt - d0); end
    n_checks++; if (det_time !== 32'd10 || det_len !== 8'd3) begin n_fail++; $display("FAIL short_hold: got time=%0d len=%0d want 10,3", det_time, det_len); end
  endtask

  task automatic test_equal_thresh;
    int d0;
    d0 = det_cnt;
    repeat (3) xs(128);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL equal_busy: got %0b want 0", busy); end
    xs(0);
    idle(3);
    n_checks++; if (det_cnt !== d0) begin n_fail++; $display("FAIL equal_no_event: got %0d events want 0", det_cnt - d0); end
  endtask

  task automatic test_holdoff_close;
    int d0;
    d0 = det_cnt;
    repeat (3) xs(256);
    below(5);
    repeat (3) xs(256);
    below(12);
    idle(3);
    n_checks++; if (det_cnt !== d0 + 1) begin n_fail++; $display("FAIL holdoff_close_count: got %0d want 1", det_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL holdoff_close_busy: got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int d0;
    int ts2;
    d0 = det_cnt;
    repeat (3) xs(256);
    below(20);
    ts2 = idx;
    xs(32'h90); xs(32'h300); xs(32'h150);
    xs(0);
    idle(1);
    n_checks++; if (detect !== 1'b1) begin n_fail++; $display("FAIL b2b_detect: got %0b want 1", detect); end
    n_checks++; if (det_time !== 32'(ts2)) begin n_fail++; $display("FAIL b2b_time: got %0d want %0d", det_time, ts2); end
    n_checks++; if (det_peak !== 33'h0_0000_0300) begin n_fail++; $display("FAIL b2b_peak: got %0h want 300", det_peak); end
    n_checks++; if (det_len !== 8'd3) begin n_fail++; $display("FAIL b2b_len: got %0d want 3", det_len); end
    idle(2);
    n_checks++; if (det_cnt !== d0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", det_cnt - d0); end
    below(16);
    idle(1);
  endtask

  task automatic test_saturate;
    int ts;
    thresh = {EW{1'b1}};
    ts = idx;
    repeat (300) xs(0);
    xs(-4);
    idle(1);
    n_checks++; if (detect !== 1'b1) begin n_fail++; $display("FAIL sat_detect: got %0b want 1", detect); end
    n_checks++; if (det_len !== 8'd255) begin n_fail++; $display("FAIL sat_len: got %0d want 255", det_len); end
    n_checks++; if (det_peak !== 33'h0_0000_0000) begin n_fail++; $display("FAIL sat_peak: got %0h want 0", det_peak); end
    n_checks++; if (det_time !== 32'(ts)) begin n_fail++; $display("FAIL sat_time: got %0d want %0d", det_time, ts); end
    thresh = 33'h0_0000_0080;
    below(16);
    idle(1);
  endtask

  task automatic test_flags;
    thresh = 33'h0_7FFF_FFFF;
    n_checks++; if (fifo_ovf !== 1'b0 || align_err !== 1'b0) begin n_fail++; $display("FAIL flags_clean: got ovf=%0b aerr=%0b want 00", fifo_ovf, align_err); end
    din = BASE; avg = BASE;
    din_valid = 1'b1;
    idle(12);
    din_valid = 1'b0;
    idle(1);
    n_checks++; if (fifo_ovf !== 1'b1 || align_err !== 1'b0) begin n_fail++; $display("FAIL flags_ovf: got ovf=%0b aerr=%0b want 10", fifo_ovf, align_err); end
    avg_valid = 1'b1;
    idle(8);
    avg_valid = 1'b0;
    idle(1);
    n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL flags_drain: got aerr=%0b want 0", align_err); end
    avg_valid = 1'b1;
    idle(1);
    avg_valid = 1'b0;
    idle(3);
    n_checks++; if (align_err !== 1'b1 || fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL flags_sticky: got ovf=%0b aerr=%0b want 11", fifo_ovf, align_err); end
  endtask

  task automatic test_reset_midrun;
    int d0;
    thresh = 33'h0_0000_0080;
    repeat (2) xs(256);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstrun_busy: got %0b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || detect !== 1'b0) begin n_fail++; $display("FAIL rstrun_async: got busy=%0b detect=%0b want 00", busy, detect); end
    n_checks++; if (det_time !== 32'd0 || det_len !== 8'd0 || det_peak !== 33'd0) begin n_fail++; $display("FAIL rstrun_fields: got time=%0d len=%0d peak=%0h want 0", det_time, det_len, det_peak); end
    n_checks++; if (fifo_ovf !== 1'b0 || align_err !== 1'b0) begin n_fail++; $display("FAIL rstrun_sticky: got ovf=%0b aerr=%0b want 00", fifo_ovf, align_err); end
    @(negedge clk);
    rst = 1'b0; idx = 0;
    d0 = det_cnt;
    xs(0);
    idle(3);
    n_checks++; if (det_cnt !== d0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstrun_no_event: got events=%0d busy=%0b want 0,0", det_cnt - d0, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_run();
    test_equal_thresh();
    test_holdoff_close();
    test_back_to_back();
    test_saturate();
    test_flags();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
